// File: rtl/branch_hazard_ctrl_if.sv
// Signal bundle between the D-stage pipeline/comparator and the branch hazard controller.
// The pipeline side is the master; the controller is the slave.
interface branch_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             d_valid;
  logic [2:0]       d_cmpop;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic             e_we;
  logic [4:0]       e_wa;
  logic             e_is_load;
  logic             m_we;
  logic [4:0]       m_wa;
  logic             m_is_load;
  logic             w_we;
  logic [4:0]       w_wa;
  logic             cmp_equal;
  logic             stall;
  logic [2:0]       cmp_op;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             redirect;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output d_valid, d_cmpop, d_rs, d_rt,
    output e_we, e_wa, e_is_load, m_we, m_wa, m_is_load, w_we, w_wa,
    output cmp_equal,
    input  stall, cmp_op, fwd_a_sel, fwd_b_sel, redirect, branch_cnt, taken_cnt
  );

  modport slave (
    input  d_valid, d_cmpop, d_rs, d_rt,
    input  e_we, e_wa, e_is_load, m_we, m_wa, m_is_load, w_we, w_wa,
    input  cmp_equal,
    output stall, cmp_op, fwd_a_sel, fwd_b_sel, redirect, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencer: stalls D on E/M operand hazards, drives comparator
// opcode and forwarding selects, turns the compare result into a redirect and counts branches.
module branch_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  branch_hazard_ctrl_if.slave bus
);

  localparam logic [2:0] OP_NONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  state_e           state_q, state_d, state_cur;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;

  logic       is_branch, uses_rt, resolve;
  logic [1:0] need_a, need_b, need;
  logic       stall_c, redirect_c;
  logic [2:0] cmp_op_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Bubbles a source register must wait for before the comparator can see its value.
  function automatic logic [1:0] src_need(input logic [4:0] r,
                                          input logic e_we, input logic [4:0] e_wa, input logic e_ld,
                                          input logic m_we, input logic [4:0] m_wa, input logic m_ld);
    if (r == 5'd0)                       return 2'd0;
    if (e_we && e_wa == r)               return e_ld ? 2'd2 : 2'd1;
    if (m_we && m_wa == r && m_ld)       return 2'd1;
    return 2'd0;
  endfunction

  // Forwarding source for one comparator operand: M (non-load) beats W beats RF.
  function automatic logic [1:0] src_fwd(input logic [4:0] r,
                                         input logic m_we, input logic [4:0] m_wa, input logic m_ld,
                                         input logic w_we, input logic [4:0] w_wa);
    if (r == 5'd0)                       return 2'd0;
    if (m_we && !m_ld && m_wa == r)      return 2'd2;
    if (w_we && w_wa == r)               return 2'd1;
    return 2'd0;
  endfunction

  assign is_branch = bus.d_valid && (bus.d_cmpop <= 3'd5);
  assign uses_rt   = (bus.d_cmpop == 3'd0) || (bus.d_cmpop == 3'd1);

  assign need_a = src_need(bus.d_rs, bus.e_we, bus.e_wa, bus.e_is_load,
                           bus.m_we, bus.m_wa, bus.m_is_load);
  assign need_b = uses_rt ? src_need(bus.d_rt, bus.e_we, bus.e_wa, bus.e_is_load,
                                     bus.m_we, bus.m_wa, bus.m_is_load) : 2'd0;
  assign need   = (need_a > need_b) ? need_a : need_b;

  // Outputs during reset follow the IDLE rules regardless of the held state.
  assign state_cur = reset ? IDLE : state_q;

  always_comb begin
    state_d    = state_cur;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    resolve    = 1'b0;
    cmp_op_c   = OP_NONE;
    fwd_a_c    = 2'd0;
    fwd_b_c    = 2'd0;
    redirect_c = 1'b0;

    unique case (state_cur)
      IDLE: begin
        if (is_branch) begin
          if (need == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = need - 2'd1;
            state_d = (need == 2'd2) ? STALL : RESOLVE;
          end
        end
      end
      STALL: begin
        if (!is_branch) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        state_d = IDLE;
        resolve = is_branch;
      end
      default: state_d = IDLE;
    endcase

    if (resolve) begin
      cmp_op_c   = bus.d_cmpop;
      fwd_a_c    = src_fwd(bus.d_rs, bus.m_we, bus.m_wa, bus.m_is_load, bus.w_we, bus.w_wa);
      fwd_b_c    = src_fwd(bus.d_rt, bus.m_we, bus.m_wa, bus.m_is_load, bus.w_we, bus.w_wa);
      redirect_c = bus.cmp_equal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (resolve) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        if (bus.cmp_equal) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall      = stall_c;
  assign bus.cmp_op     = cmp_op_c;
  assign bus.fwd_a_sel  = fwd_a_c;
  assign bus.fwd_b_sel  = fwd_b_c;
  assign bus.redirect   = redirect_c;
  assign bus.branch_cnt = branch_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: per-cycle expectations go through a scoreboard queue,
// counters are tracked by a bench-side tally; built with 4-bit counters to reach the wrap.
module tb_branch_hazard_ctrl;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic       stall;
    logic [2:0] cmp_op;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       redirect;
    logic       resolve;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  logic [CNT_W-1:0] exp_branch = '0;
  logic [CNT_W-1:0] exp_taken  = '0;

  branch_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic eq);
    bus.d_valid = v; bus.d_cmpop = op; bus.d_rs = rs; bus.d_rt = rt; bus.cmp_equal = eq;
  endtask

  task automatic set_pipe(input logic ewe, input logic [4:0] ewa, input logic eld,
                          input logic mwe, input logic [4:0] mwa, input logic mld,
                          input logic wwe, input logic [4:0] wwa);
    bus.e_we = ewe; bus.e_wa = ewa; bus.e_is_load = eld;
    bus.m_we = mwe; bus.m_wa = mwa; bus.m_is_load = mld;
    bus.w_we = wwe; bus.w_wa = wwa;
  endtask

  // One cycle: queue expectation, compare combinational outputs mid-cycle, then counters after the edge.
  task automatic step(input string tag, input logic st, input logic [2:0] op,
                      input logic [1:0] fa, input logic [1:0] fb, input logic red, input logic res);
    exp_t e;
    sb_q.push_back('{stall: st, cmp_op: op, fwd_a: fa, fwd_b: fb, redirect: red, resolve: res});
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, ".stall"},    32'(bus.stall),     32'(e.stall));
    check({tag, ".cmp_op"},   32'(bus.cmp_op),    32'(e.cmp_op));
    check({tag, ".fwd_a"},    32'(bus.fwd_a_sel), 32'(e.fwd_a));
    check({tag, ".fwd_b"},    32'(bus.fwd_b_sel), 32'(e.fwd_b));
    check({tag, ".redirect"}, 32'(bus.redirect),  32'(e.redirect));
    if (reset) begin
      exp_branch = '0;
      exp_taken  = '0;
    end else if (e.resolve) begin
      exp_branch = exp_branch + CNT_W'(1);
      if (e.redirect) exp_taken = exp_taken + CNT_W'(1);
    end
    @(posedge clk);
    #1;
    check({tag, ".branch_cnt"}, 32'(bus.branch_cnt), 32'(exp_branch));
    check({tag, ".taken_cnt"},  32'(bus.taken_cnt),  32'(exp_taken));
  endtask

  initial begin
    reset = 1'b1;
    set_d(1'b0, 3'd7, 5'd0, 5'd0, 1'b0);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("reset0", 1'b0, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    step("reset1", 1'b0, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // No hazard BEQ, taken
    set_d(1'b1, 3'd0, 5'd3, 5'd4, 1'b1);
    set_pipe(1'b1, 5'd10, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1, 5'd12);
    step("nohaz", 1'b0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1);

    // BNE with ALU producer in E: one stall, then forward from M
    set_d(1'b1, 3'd1, 5'd5, 5'd6, 1'b0);
    set_pipe(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("alu_e.stall", 1'b1, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
    step("alu_e.res", 1'b0, 3'd1, 2'd2, 2'd0, 1'b0, 1'b1);

    // BGTZ with load in E: two stalls, then forward from W
    set_d(1'b1, 3'd3, 5'd8, 5'd0, 1'b1);
    set_pipe(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("ld_e.stall1", 1'b1, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0);
    step("ld_e.stall2", 1'b1, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    step("ld_e.res", 1'b0, 3'd3, 2'd1, 2'd0, 1'b1, 1'b1);

    // BLEZ ignores rt even when E writes it
    set_d(1'b1, 3'd2, 5'd2, 5'd9, 1'b0);
    set_pipe(1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("rt_ignored", 1'b0, 3'd2, 2'd0, 2'd0, 1'b0, 1'b1);

    // Register 0 never hazards or forwards
    set_d(1'b1, 3'd0, 5'd0, 5'd0, 1'b1);
    set_pipe(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0);
    step("reg0", 1'b0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1);

    // BEQ rt hazard on load in M: one stall, then forward B from W
    set_d(1'b1, 3'd0, 5'd1, 5'd7, 1'b1);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0);
    step("ld_m_rt.stall", 1'b1, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
    step("ld_m_rt.res", 1'b0, 3'd0, 2'd0, 2'd1, 1'b1, 1'b1);

    // Branch right after a resolve is evaluated fresh
    set_d(1'b1, 3'd1, 5'd3, 5'd4, 1'b1);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("b2b", 1'b0, 3'd1, 2'd0, 2'd0, 1'b1, 1'b1);

    // Reset during first stall cycle: outputs follow IDLE, counters clear
    set_d(1'b1, 3'd5, 5'd8, 5'd0, 1'b0);
    set_pipe(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("rst_mid.stall", 1'b1, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("rst_mid.rst", 1'b0, 3'd5, 2'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    set_d(1'b0, 3'd7, 5'd0, 5'd0, 1'b0);
    step("rst_mid.idle", 1'b0, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);

    // d_valid dropped in STALL aborts without counting
    set_d(1'b1, 3'd5, 5'd8, 5'd0, 1'b1);
    set_pipe(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step("abort.stall", 1'b1, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    set_d(1'b0, 3'd5, 5'd8, 5'd0, 1'b1);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0);
    step("abort.drop", 1'b0, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
    set_d(1'b1, 3'd6, 5'd8, 5'd0, 1'b1);
    set_pipe(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    step("abort.nonbr", 1'b0, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0);

    // 16 no-hazard branches wrap the 4-bit branch counter; redirect still tracks cmp_equal
    set_pipe(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      set_d(1'b1, 3'd4, 5'd6, 5'd0, 1'(i % 2));
      step($sformatf("wrap%0d", i), 1'b0, 3'd4, 2'd0, 2'd0, 1'(i % 2), 1'b1);
    end
    check("wrap.final_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    check("wrap.final_taken_cnt",  32'(bus.taken_cnt),  32'd8);

    set_d(1'b0, 3'd7, 5'd0, 5'd0, 1'b0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

- Decode-stage controller that sequences the branch comparator.
- Per branch in D, it detects operand hazards against the E/M pipeline registers and stalls D for the required number of cycles.
- It drives the comparator's operand forwarding selects and CMP opcode, then converts the comparator result into the next-PC redirect.
- It keeps resolved/taken branch counters for performance monitoring.

## Interface

Parameters:
- CNT_W, 32, width of the branch/taken statistics counters

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears FSM and counters
- d_valid  in  1  D stage holds a valid instruction
- d_cmpop  in  3  CMP opcode of D instruction: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6/7 not a branch
- d_rs  in  5  source register A
- d_rt  in  5  source register B (used only by BEQ/BNE)
- e_we  in  1  E instruction writes a register
- e_wa  in  5  E destination
- e_is_load  in  1  E instruction is a load
- m_we  in  1  M instruction writes a register
- m_wa  in  5  M destination
- m_is_load  in  1  M instruction is a load
- w_we  in  1  W instruction writes a register
- w_wa  in  5  W destination
- cmp_equal  in  1  comparator result for the currently driven cmp_op/operands
- stall  out  1  freeze PC and F/D register, insert bubble into E
- cmp_op  out  3  opcode to comparator
- fwd_a_sel  out  2  comparator operand A source: 0 RF, 1 W, 2 M
- fwd_b_sel  out  2  comparator operand B source, same encoding
- redirect  out  1  select branch target for next PC
- branch_cnt  out  CNT_W  resolved branches since reset
- taken_cnt  out  CNT_W  taken branches since reset

## Operation

- A D instruction is a branch when d_valid=1 and d_cmpop<=5.
- Sources needing check: rs always; rt only for BEQ/BNE. Register 0 never causes a hazard or forward.
- Per-source stall need:
  - matches e_wa with e_we: 2 if e_is_load, else 1
  - else matches m_wa with m_we and m_is_load: 1
  - else 0
- Branch need = max over checked sources (0..2).
- FSM states: IDLE, STALL, RESOLVE. 2-bit down-counter cnt.
- IDLE:
  - non-branch: stall=0, redirect=0
  - branch with need=0: resolve this cycle (see below), stay IDLE
  - branch with need>0: stall=1, cnt<=need-1, next STALL if need=2, else RESOLVE
- STALL: stall=1, cnt decrements. Exit to RESOLVE when cnt reaches 0.
- RESOLVE:
  - stall=0; resolve this cycle; next IDLE
  - The state holds for one cycle, so the F/D register advances and D presents the next instruction in IDLE.
- Abort: if d_valid=0 or d_cmpop>5 in STALL or RESOLVE, go to IDLE. stall=0, redirect=0, and no count in that cycle.
- Resolve cycle:
  - cmp_op=d_cmpop
  - fwd selects from live inputs, per operand: M match (m_we, !m_is_load, nonzero) gives 2; else W match (w_we, nonzero) gives 1; else 0
  - redirect=cmp_equal
  - branch_cnt+=1; taken_cnt+=1 if cmp_equal
- Non-resolve cycles: cmp_op=7, fwd selects 0, redirect=0.
- Counters wrap modulo 2^CNT_W.
- Need is evaluated only in IDLE. It is not re-evaluated in STALL, because D is held and bubbles advance deterministically.

## Timing

- stall, cmp_op, fwd_*_sel and redirect are combinational from state and inputs, valid in the same cycle as detection.
- Branch latency: 0 stall cycles with no hazard; 1 with an ALU producer in E or a load in M; 2 with a load in E.
- stall is asserted for exactly need consecutive cycles. Resolution occurs in the first cycle after, with stall=0.
- Reset values (taking effect on the edge where reset=1): state IDLE, cnt 0, branch_cnt 0, taken_cnt 0.
- During reset, combinational outputs follow IDLE rules.
- Reset mid-STALL: IDLE on the next edge with no count, so stall drops unless the held branch re-triggers.
- Branch immediately following a resolved branch (delay slot is a branch) is evaluated fresh in IDLE.
- Counter overflow: 0xFFFFFFFF+1 goes to 0 without affecting other outputs.

## Test plan

- No hazard: BEQ rs=3, rt=4, E/M/W writing other regs, cmp_equal=1 -> stall=0, cmp_op=0, fwd=0/0, redirect=1 same cycle; branch_cnt=1, taken_cnt=1 next cycle.
- ALU in E: BNE rs=5 with e_we=1, e_wa=5, e_is_load=0 -> stall=1 for 1 cycle. Next cycle (producer in M, m_wa=5) fwd_a_sel=2, cmp_op=1, redirect=cmp_equal.
- Load in E: BGTZ rs=8 with e_wa=8, e_is_load=1 -> stall=1 for 2 cycles, then resolve with fwd_a_sel=1 (producer in W).
- rt ignored: BLEZ rs=2, rt=9, e_wa=9 ALU -> stall=0, resolves immediately. Register 0: BEQ rs=0, rt=0, e_wa=0 -> no stall.
- Abort/reset: load-in-E hazard, then reset high during the first stall cycle -> IDLE, counters 0. Separately, d_valid dropped in STALL -> stall=0, no count.
- Counter wrap: preload via 2^32-1 branches (or CNT_W=4 build with 16 branches) -> branch_cnt wraps to 0 and redirect behaviour is unchanged.
